// File: rtl/sr_drv_pkg.sv
// -----------------------------------------------------------------------------
// sr_drv_pkg
//   Shared types and constants for the SR latch driver.
//   - sr_state_t : driver FSM states (CHECK only reachable when the
//                  SR_READBACK_EN macro is defined).
//   - sr_cmd_t   : command encoding (clear / set).
//   - SR_FB_SET / SR_FB_CLR : expected {q_fb, qbar_fb} for a set / cleared latch.
//   - sr_fb_expected() : maps the shadow latch state to its expected readback.
// -----------------------------------------------------------------------------
package sr_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    DEAD  = 2'd2,
    CHECK = 2'd3
  } sr_state_t;

  typedef enum logic {
    SR_CLR = 1'b0,
    SR_SET = 1'b1
  } sr_cmd_t;

  localparam logic [1:0] SR_FB_SET = 2'b10;
  localparam logic [1:0] SR_FB_CLR = 2'b01;

  function automatic logic [1:0] sr_fb_expected(input logic shadow);
    return shadow ? SR_FB_SET : SR_FB_CLR;
  endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// -----------------------------------------------------------------------------
// sr_latch_driver_if
//   Bundles the command handshake, the latch drive pins and the latch readback
//   of the SR latch driver.
//   Signals:
//     cmd_valid, cmd_set   : command from the controller
//     cmd_ready, busy      : driver idle / busy status
//     S, R                 : drive pulses to the external SR latch
//     shadow_q             : driver's record of the latch state
//     q_fb, qbar_fb        : latch Q / Qbar readback
//     fault                : sticky readback mismatch flag
//   Modports:
//     slave  : the driver itself
//     master : its environment (controller plus the latch readback pins)
// -----------------------------------------------------------------------------
interface sr_latch_driver_if;

  logic cmd_valid;
  logic cmd_set;
  logic cmd_ready;
  logic S;
  logic R;
  logic busy;
  logic shadow_q;
  logic q_fb;
  logic qbar_fb;
  logic fault;

  modport slave (
    input  cmd_valid, cmd_set, q_fb, qbar_fb,
    output cmd_ready, S, R, busy, shadow_q, fault
  );

  modport master (
    output cmd_valid, cmd_set, q_fb, qbar_fb,
    input  cmd_ready, S, R, busy, shadow_q, fault
  );

endinterface

// File: rtl/sr_pulse_timer.sv
// -----------------------------------------------------------------------------
// sr_pulse_timer
//   Loadable down-counter shared by the PULSE and DEAD phases.
//   Ports:
//     clk      in  clock, rising edge
//     rst      in  asynchronous active-high reset (counter clears to 0)
//     load     in  load load_val this edge (takes priority over counting)
//     load_val in  value to load; a phase of N cycles loads N-1
//     done     out counter is at zero (last cycle of the current phase)
//   The counter stops at zero and never wraps; it only moves again on a load.
// -----------------------------------------------------------------------------
module sr_pulse_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// -----------------------------------------------------------------------------
// sr_latch_driver
//   Converts single-cycle set/clear commands into timed, mutually exclusive
//   S/R drive pulses for an external SR latch and keeps a shadow copy of the
//   latch state.
//   Parameters:
//     PULSE_CYC : cycles S or R is held high per command (>= 1)
//     DEAD_CYC  : cycles S=R=0 after each pulse (>= 0; 0 skips the DEAD phase)
//   Ports:
//     clk : clock, rising edge
//     rst : asynchronous active-high reset
//     bus : sr_latch_driver_if.slave (handshake, S/R, shadow, readback, fault)
//   Build option:
//     SR_READBACK_EN defined : one CHECK cycle after DEAD compares
//       {q_fb,qbar_fb} with the expected value; any mismatch (including X/Z)
//       sets the sticky fault flag until rst.
//     SR_READBACK_EN undefined : no CHECK cycle, readback ignored, fault = 0.
// -----------------------------------------------------------------------------
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_CYC = 4,
  parameter int DEAD_CYC  = 2
) (
  input  logic               clk,
  input  logic               rst,
  sr_latch_driver_if.slave   bus
);

  localparam int CNT_MAX = (PULSE_CYC > DEAD_CYC) ? PULSE_CYC : DEAD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // A phase of N cycles is loaded as N-1 and ends on the edge where done=1.
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] DEAD_LOAD  = (DEAD_CYC > 0) ? CNT_W'(DEAD_CYC - 1) : '0;

`ifdef SR_READBACK_EN
  localparam sr_state_t AFTER_DEAD = CHECK;
`else
  localparam sr_state_t AFTER_DEAD = IDLE;
`endif

  sr_state_t        state_q, state_d;
  sr_cmd_t          cmd_q, cmd_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             ready_q, ready_d;
  logic             shadow_q, shadow_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  sr_pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // State and output registers. Every drive pin resets to 0 directly, so an
  // asynchronous reset mid-pulse can only take S/R low, never both high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cmd_q    <= SR_CLR;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      ready_q  <= 1'b1;
      shadow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      s_q      <= s_d;
      r_q      <= r_d;
      ready_q  <= ready_d;
      shadow_q <= shadow_d;
    end
  end

  // Next-state logic. cmd_ready is registered high exactly while in IDLE, so
  // the handshake reduces to cmd_valid there and commands offered while busy
  // are simply not seen.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.cmd_valid) state_d = PULSE;
      PULSE:   if (tmr_done)      state_d = (DEAD_CYC > 0) ? DEAD : AFTER_DEAD;
      DEAD:    if (tmr_done)      state_d = AFTER_DEAD;
      CHECK:                      state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Output / datapath logic. S, R and cmd_ready are registered decodes of the
  // next state, so the pins change only on clock edges and S and R can never
  // both be high: they are decoded from complementary values of cmd_d.
  always_comb begin
    cmd_d    = cmd_q;
    shadow_d = shadow_q;
    tmr_load = 1'b0;
    tmr_val  = PULSE_LOAD;

    if (state_q == IDLE && bus.cmd_valid) begin
      cmd_d    = sr_cmd_t'(bus.cmd_set);
      tmr_load = 1'b1;
      tmr_val  = PULSE_LOAD;
    end

    if (state_q == PULSE && tmr_done) begin
      shadow_d = cmd_q;
      if (DEAD_CYC > 0) begin
        tmr_load = 1'b1;
        tmr_val  = DEAD_LOAD;
      end
    end

    s_d     = (state_d == PULSE) && (cmd_d == SR_SET);
    r_d     = (state_d == PULSE) && (cmd_d == SR_CLR);
    ready_d = (state_d == IDLE);
  end

`ifdef SR_READBACK_EN
  logic fault_q;
  logic fault_d;

  // Written as "match keeps, otherwise set" so an X/Z readback falls into the
  // else branch and raises the fault instead of being silently ignored.
  always_comb begin
    fault_d = fault_q;
    if (state_q == CHECK) begin
      if ({bus.q_fb, bus.qbar_fb} == sr_fb_expected(shadow_q)) begin
        fault_d = fault_q;
      end else begin
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign bus.fault = fault_q;
`else
  // Readback pins stay on the port list but carry no function in this build.
  logic unused_fb;
  assign unused_fb = bus.q_fb ^ bus.qbar_fb;
  assign bus.fault = 1'b0;
`endif

  assign bus.S         = s_q;
  assign bus.R         = r_q;
  assign bus.cmd_ready = ready_q;
  assign bus.busy      = ~ready_q;
  assign bus.shadow_q  = shadow_q;

endmodule
